cache_ctrl_fsm: RTL and testbench
=================================

// Module: cache_ctrl_fsm
// PURPOSE
// - Controller for the direct-mapped, write-back, write-allocate cache. It drives the single-port
//   tag store (cache_tag) and the data store (cache_data) through cache_req_type requests.
// - Serves 32-bit CPU loads/stores; on a miss, writes back a dirty victim, then refills a
//   128-bit block from main memory.
// - Sits between the RV32I LSU and the memory bus, inside cache_top.
// PARAMETERS (values mirrored as constants in cache_def)
// - NUM_LINES   512  cache lines; index width = 9
// - BLOCK_BITS  128  line size (4 x 32-bit words); offset = addr[3:0], word select = addr[3:2]
// - TAG_BITS    19   addr[31:13]
// PORTS
// - clk_i         in   1    clock; all state updates on posedge
// - rst_i         in   1    synchronous, active-high reset
// - cpu_req_i     in   66   cpu_req_type {addr[31:0], data[31:0], rw (1=store), valid}
// - cpu_res_o     out  33   cpu_result_type {data[31:0], ready}
// - mem_req_o     out  162  mem_req_type {addr[31:0], data[127:0], rw (1=write), valid}
// - mem_data_i    in   129  mem_data_type {data[127:0], ready}
// - tag_req_o     out  10   cache_req_type {index[8:0], we} to tag store
// - tag_write_o   out  21   cache_tag_type {valid, dirty, tag[18:0]}
// - tag_read_i    in   21   cache_tag_type; combinational read of tag_req_o.index
// - data_req_o    out  10   cache_req_type to data store
// - data_write_o  out  128  block to write
// - data_read_i   in   128  combinational read of data_req_o.index
// BEHAVIOUR
// - Reset: state=IDLE; all valid/ready/we outputs 0; address and data outputs 0.
//   Tag/data arrays are not cleared by reset.
// - Reset mid-miss: mem_req_o.valid drops in the next cycle. The memory side must tolerate
//   an abandoned transaction.
// - States:
//   - IDLE: on cpu_req_i.valid, latch the request into req_q -> COMPARE.
//   - COMPARE: index=req_q.addr[12:4].
//     - Hit (tag_read_i.valid && tag equal):
//       - cpu_res_o.ready=1 for exactly this cycle.
//       - Load: data = word addr[3:2] of data_read_i.
//       - Store: data_req.we=1 with the word merged into data_read_i; tag_req.we=1 with
//         {1, 1, tag}.
//       - -> IDLE.
//     - Miss: latch victim address {tag_read_i.tag, index, 4'b0}.
//       -> WRITE_BACK if tag_read_i.valid && tag_read_i.dirty, else -> ALLOCATE.
//   - WRITE_BACK: mem_req {victim addr, data_read_i, rw=1, valid=1} held until
//     mem_data_i.ready -> ALLOCATE.
//   - ALLOCATE: mem_req {req_q.addr & ~32'hF, rw=0, valid=1} held until mem_data_i.ready.
//     In that cycle: data_req.we=1 with mem_data_i.data; tag_req.we=1 with
//     {1, 0, req_q tag}; -> COMPARE.
//     The re-compare then hits, and a store marks the line dirty.
// - Latency: hit = 2 cycles from valid in IDLE to ready. Miss = 3 + memory cycles
//   (+ write-back cycles if dirty).
// - CPU holds cpu_req_i stable until ready. cpu_req_i is sampled only in IDLE, so requests
//   outside IDLE are ignored.
// - Back-to-back: a new valid in the cycle after ready is accepted (IDLE -> COMPARE).
// - mem_data_i.ready while mem_req_o.valid=0 is ignored.
// - Invalid line: any tag match is a miss; no write-back regardless of the dirty bit.
// - Full word stores only (no byte enables). Byte lanes are merged in the LSU.
// STRUCTURE
// - cache_def: cpu_req_type, cpu_result_type, mem_req_type, mem_data_type, cache_req_type,
//   cache_tag_type, cache_data_type, TAGMSB/TAGLSB and index constants,
//   and cache_state_type enum {IDLE, COMPARE, WRITE_BACK, ALLOCATE}.
// - Single module: FSM, request/victim registers, word select/merge logic.
//   No sub-module; cache_top instantiates this block alongside cache_tag and cache_data.
// TESTING
// 1. Cold load 0x0000_1004 -> miss, no write-back; mem read at 0x0000_1000 returns
//    0xDDDD_CCCC_BBBB_AAAA_... -> ready with data = word 1. Tag[0x100] = {1,0,0x00000}.
// 2. Store 0xDEADBEEF to 0x0000_1008 after (1) -> hit, ready after 2 cycles.
//    Tag[0x100].dirty=1; word 2 = 0xDEADBEEF; no mem request.
// 3. Load 0x0000_3008 (same index, tag 0x1) after (2) -> WRITE_BACK to 0x0000_1000 carrying
//    the merged block, then ALLOCATE at 0x0000_3000. Tag becomes {1,0,0x1}.
// 4. Memory ready delayed 5 cycles in WRITE_BACK and ALLOCATE -> mem_req_o stable and valid
//    throughout. cpu_res_o.ready stays 0 until the re-compare.
// 5. rst_i asserted during ALLOCATE -> next cycle IDLE, mem_req_o.valid=0, ready=0.
//    A following load completes normally.
// 6. Two back-to-back hits to 0x0000_1000/0x0000_1004 -> ready pulses on cycles 2 and 4
//    with correct words.

Source files
------------

// File: rtl/cache_ctrl_fsm_pkg.sv
// Shared types and constants for the direct-mapped write-back cache controller.
// Field layouts match the tag/data stores and the memory bus inside cache_top.
package cache_ctrl_fsm_pkg;

  localparam int NUM_LINES  = 512;
  localparam int INDEX_BITS = 9;
  localparam int BLOCK_BITS = 128;
  localparam int TAG_BITS   = 19;
  localparam int TAGMSB     = 31;
  localparam int TAGLSB     = 13;
  localparam int IDXMSB     = 12;
  localparam int IDXLSB     = 4;

  typedef logic [1:0] cache_state_type;
  localparam cache_state_type IDLE       = 2'd0;
  localparam cache_state_type COMPARE    = 2'd1;
  localparam cache_state_type WRITE_BACK = 2'd2;
  localparam cache_state_type ALLOCATE   = 2'd3;

  typedef logic [BLOCK_BITS-1:0] cache_data_type;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

  typedef struct packed {
    logic [INDEX_BITS-1:0] index;
    logic                  we;
  } cache_req_type;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAG_BITS-1:0] tag;
  } cache_tag_type;

  function automatic logic [31:0] get_word(cache_data_type blk, logic [1:0] sel);
    return blk[32*sel +: 32];
  endfunction

  function automatic cache_data_type merge_word(cache_data_type blk, logic [1:0] sel,
                                                logic [31:0] word);
    cache_data_type res;
    res = blk;
    res[32*sel +: 32] = word;
    return res;
  endfunction

endpackage

// File: rtl/cache_ctrl_fsm_if.sv
// Bundles the CPU, memory-bus and tag/data-store connections of the cache controller.
// master = controller side, slave = environment (LSU, memory, stores).
interface cache_ctrl_fsm_if;
  import cache_ctrl_fsm_pkg::*;

  cpu_req_type    cpu_req;
  cpu_result_type cpu_res;
  mem_req_type    mem_req;
  mem_data_type   mem_data;
  cache_req_type  tag_req;
  cache_tag_type  tag_write;
  cache_tag_type  tag_read;
  cache_req_type  data_req;
  cache_data_type data_write;
  cache_data_type data_read;

  modport master (
    input  cpu_req, mem_data, tag_read, data_read,
    output cpu_res, mem_req, tag_req, tag_write, data_req, data_write
  );

  modport slave (
    output cpu_req, mem_data, tag_read, data_read,
    input  cpu_res, mem_req, tag_req, tag_write, data_req, data_write
  );

endinterface

// File: rtl/cache_ctrl_fsm.sv
// Cache controller FSM: hit service, dirty-victim write-back and block refill.
// All outputs decode combinationally from the state and the latched request.
module cache_ctrl_fsm
  import cache_ctrl_fsm_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  cache_ctrl_fsm_if.master bus
);

  cache_state_type       state_q, state_d;
  cpu_req_type           req_q;
  logic [31:0]           victim_addr_q;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  hit;

  assign index   = req_q.addr[IDXMSB:IDXLSB];
  assign req_tag = req_q.addr[TAGMSB:TAGLSB];
  // An invalid line never hits, whatever its stored tag says.
  assign hit     = bus.tag_read.valid && (bus.tag_read.tag == req_tag);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      req_q         <= '0;
      victim_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.cpu_req.valid)
        req_q <= bus.cpu_req;
      if (state_q == COMPARE && !hit)
        victim_addr_q <= {bus.tag_read.tag, index, 4'b0};
    end
  end

  // NOTE: every output and state_d gets a default before the case so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    bus.cpu_res    = '0;
    bus.mem_req    = '0;
    bus.tag_req    = '0;
    bus.tag_write  = '0;
    bus.data_req   = '0;
    bus.data_write = '0;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req.valid)
          state_d = COMPARE;
      end

      COMPARE: begin
        bus.tag_req.index  = index;
        bus.data_req.index = index;
        if (hit) begin
          bus.cpu_res.ready = 1'b1;
          if (req_q.rw) begin
            bus.data_req.we = 1'b1;
            bus.data_write  = merge_word(bus.data_read, req_q.addr[3:2], req_q.data);
            bus.tag_req.we  = 1'b1;
            bus.tag_write   = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
          end else begin
            bus.cpu_res.data = get_word(bus.data_read, req_q.addr[3:2]);
          end
          state_d = IDLE;
        end else if (bus.tag_read.valid && bus.tag_read.dirty) begin
          state_d = WRITE_BACK;
        end else begin
          state_d = ALLOCATE;
        end
      end

      WRITE_BACK: begin
        // The data store is indexed by the same line, so the victim block is on data_read.
        bus.tag_req.index  = index;
        bus.data_req.index = index;
        bus.mem_req = '{addr: victim_addr_q, data: bus.data_read, rw: 1'b1, valid: 1'b1};
        if (bus.mem_data.ready)
          state_d = ALLOCATE;
      end

      ALLOCATE: begin
        bus.tag_req.index  = index;
        bus.data_req.index = index;
        bus.mem_req.addr   = req_q.addr & ~32'hF;
        bus.mem_req.valid  = 1'b1;
        if (bus.mem_data.ready) begin
          bus.data_req.we = 1'b1;
          bus.data_write  = bus.mem_data.data;
          bus.tag_req.we  = 1'b1;
          bus.tag_write   = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
          state_d         = COMPARE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed scoreboard bench for cache_ctrl_fsm with tag/data store and main-memory models.
module tb_cache_ctrl_fsm;
  import cache_ctrl_fsm_pkg::*;

  typedef struct {
    logic        rw;
    logic [31:0] data;
    int          issue;
    int          lat;
  } exp_t;

  logic clk_i;
  logic rst_i;
  cache_ctrl_fsm_if bus();

  cache_ctrl_fsm dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t exp_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Tag and data stores: combinational read, write on the clock edge.
  logic          tb_clear;
  logic          poke_en;
  logic [8:0]    poke_idx;
  cache_tag_type poke_val;
  cache_tag_type  tag_mem  [NUM_LINES];
  cache_data_type data_mem [NUM_LINES];

  assign bus.tag_read  = tag_mem[bus.tag_req.index];
  assign bus.data_read = data_mem[bus.data_req.index];

  always @(posedge clk_i) begin
    if (tb_clear) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (poke_en) tag_mem[poke_idx] <= poke_val;
      if (bus.tag_req.we) tag_mem[bus.tag_req.index] <= bus.tag_write;
      if (bus.data_req.we) data_mem[bus.data_req.index] <= bus.data_write;
    end
  end

  // Main memory: ready is a registered one-cycle pulse after mem_delay waiting cycles.
  logic [127:0] mm [logic [31:0]];
  int           mem_delay;
  int           wait_cnt;
  logic         mem_rdy;
  logic [127:0] mem_rdata;
  int           rd_count, wr_count;
  logic [31:0]  last_wb_addr;
  logic [127:0] last_wb_data;

  function automatic logic [127:0] lookup(logic [31:0] a);
    if (mm.exists(a)) return mm[a];
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  assign bus.mem_data = mem_data_type'({mem_rdata, mem_rdy});

  always @(posedge clk_i) begin
    if (tb_clear) begin
      mm[32'h1000] = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
      mm[32'h3000] = {32'h33330003, 32'h33330002, 32'h33330001, 32'h33330000};
      wait_cnt     <= 0;
      mem_rdy      <= 1'b0;
      mem_rdata    <= '0;
      rd_count     <= 0;
      wr_count     <= 0;
      last_wb_addr <= '0;
      last_wb_data <= '0;
    end else begin
      mem_rdy <= 1'b0;
      if (bus.mem_req.valid && !mem_rdy) begin
        if (wait_cnt == mem_delay) begin
          wait_cnt <= 0;
          mem_rdy  <= 1'b1;
          if (bus.mem_req.rw) begin
            mm[bus.mem_req.addr] = bus.mem_req.data;
            wr_count     <= wr_count + 1;
            last_wb_addr <= bus.mem_req.addr;
            last_wb_data <= bus.mem_req.data;
          end else begin
            mem_rdata <= lookup(bus.mem_req.addr);
            rd_count  <= rd_count + 1;
          end
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end else begin
        wait_cnt <= 0;
      end
    end
  end

  // Scoreboard monitor: pops one expectation per ready pulse.
  int ready_cyc_last = 0;
  int ready_cyc_prev = 0;

  always @(negedge clk_i) begin
    if (!rst_i && bus.cpu_res.ready) begin
      check("sb_has_entry", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (!e.rw) check("load_data", bus.cpu_res.data, e.data);
        check("latency", cyc - e.issue + 1, e.lat);
      end
      ready_cyc_prev <= ready_cyc_last;
      ready_cyc_last <= cyc;
    end
  end

  // While a memory request waits for ready it must hold still and the CPU must see no ready.
  logic        stab_en;
  logic        prev_pending = 1'b0;
  mem_req_type prev_req;

  always @(negedge clk_i) begin
    if (stab_en && prev_pending)
      check("mem_req_stable", {bus.mem_req, bus.cpu_res.ready}, {prev_req, 1'b0});
    prev_pending <= bus.mem_req.valid && !bus.mem_data.ready;
    prev_req     <= bus.mem_req;
  end

  // Caller is at posedge+1; returns at posedge+1 of the cycle after ready.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] data, input logic rw,
                        input logic [31:0] exp_data, input int exp_lat);
    int   n;
    logic seen;
    exp_q.push_back('{rw: rw, data: exp_data, issue: cyc, lat: exp_lat});
    bus.cpu_req = '{addr: addr, data: data, rw: rw, valid: 1'b1};
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk_i);
      seen = bus.cpu_res.ready;
      n++;
    end
    check("req_done", seen, 1'b1);
    @(posedge clk_i);
    #1;
    bus.cpu_req.valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   mem_ops;
    rst_i     = 1'b1;
    tb_clear  = 1'b1;
    poke_en   = 1'b0;
    poke_idx  = '0;
    poke_val  = '0;
    mem_delay = 0;
    stab_en   = 1'b0;
    bus.cpu_req = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_outputs",
          {bus.cpu_res, bus.mem_req, bus.tag_req, bus.tag_write, bus.data_req},
          '0);
    check("reset_data_write", bus.data_write, '0);
    rst_i    = 1'b0;
    tb_clear = 1'b0;

    // 1: cold load miss, clean refill
    do_req(32'h0000_1004, 32'h0, 1'b0, 32'hBBBBBBBB, 5);
    check("t1_tag", tag_mem[9'h100], {1'b1, 1'b0, 19'h0});
    check("t1_mem_ops", {rd_count, wr_count}, {32'd1, 32'd0});

    // 2: store hit marks the line dirty without touching memory
    mem_ops = rd_count + wr_count;
    do_req(32'h0000_1008, 32'hDEADBEEF, 1'b1, 32'h0, 2);
    check("t2_tag", tag_mem[9'h100], {1'b1, 1'b1, 19'h0});
    check("t2_word", data_mem[9'h100][95:64], 32'hDEADBEEF);
    check("t2_no_mem", rd_count + wr_count, mem_ops);

    // 3: conflicting load evicts the dirty line
    do_req(32'h0000_3008, 32'h0, 1'b0, 32'h33330002, 7);
    check("t3_wb_addr", last_wb_addr, 32'h0000_1000);
    check("t3_wb_data", last_wb_data,
          {32'hDDDDDDDD, 32'hDEADBEEF, 32'hBBBBBBBB, 32'hAAAAAAAA});
    check("t3_tag", tag_mem[9'h100], {1'b1, 1'b0, 19'h1});

    // 4: slow memory on both write-back and allocate
    do_req(32'h0000_3004, 32'hCAFEF00D, 1'b1, 32'h0, 2);
    mem_delay = 5;
    stab_en   = 1'b1;
    do_req(32'h0000_1000, 32'h0, 1'b0, 32'hAAAAAAAA, 17);
    stab_en   = 1'b0;
    mem_delay = 0;
    check("t4_wb_addr", last_wb_addr, 32'h0000_3000);
    check("t4_wb_data", last_wb_data,
          {32'h33330003, 32'h33330002, 32'hCAFEF00D, 32'h33330000});

    // 5: reset while allocating abandons the memory transaction
    mem_delay = 20;
    bus.cpu_req = '{addr: 32'h0000_7014, data: 32'h0, rw: 1'b0, valid: 1'b1};
    n = 0;
    while (!(bus.mem_req.valid && !bus.mem_req.rw) && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("t5_alloc_reached", {bus.mem_req.valid, bus.mem_req.rw}, 2'b10);
    rst_i = 1'b1;
    bus.cpu_req.valid = 1'b0;
    @(posedge clk_i);
    #1;
    check("t5_rst_mem_valid", bus.mem_req.valid, 1'b0);
    check("t5_rst_ready", bus.cpu_res.ready, 1'b0);
    rst_i     = 1'b0;
    mem_delay = 0;
    do_req(32'h0000_7014, 32'h0, 1'b0, 32'h0000_7014, 5);

    // 6: back-to-back hits
    do_req(32'h0000_1000, 32'h0, 1'b0, 32'hAAAAAAAA, 2);
    do_req(32'h0000_1004, 32'h0, 1'b0, 32'hBBBBBBBB, 2);
    check("t6_spacing", ready_cyc_last - ready_cyc_prev, 2);

    // 7: invalid line with dirty bit set and matching tag: clean miss
    poke_en  = 1'b1;
    poke_idx = 9'h002;
    poke_val = '{valid: 1'b0, dirty: 1'b1, tag: 19'h0};
    @(posedge clk_i);
    #1;
    poke_en = 1'b0;
    mem_ops = wr_count;
    do_req(32'h0000_0024, 32'h0, 1'b0, 32'h0000_0024, 5);
    check("t7_no_wb", wr_count, mem_ops);
    check("t7_tag", tag_mem[9'h002], {1'b1, 1'b0, 19'h0});

    repeat (3) @(posedge clk_i);
    #1;
    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
